dual_issue_hazard_ctrl: RTL and testbench

//  Issue/hazard controller for the dual-issue REG->EX boundary. Tracks in-flight register

---
 rtl/dual_issue_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dual_issue_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_hazard_ctrl.sv
// Issue/hazard control at the dual-issue REG->EX boundary: countdown scoreboard of in-flight
// register writes, bundle splitting on intra-bundle dependencies, and front-end stall.
//
//   state  | meaning
//   NORMAL | both REG-stage pipes undecided
//   SPLIT  | pipe1 already issued, pipe2 held in REG
module dual_issue_hazard_ctrl #(
    parameter int DEPTH   = 8,
    parameter int MAX_LAT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_REG1,
    input  logic       valid_REG2,
    input  logic       regWriteEnable_REG1,
    input  logic       regWriteEnable_REG2,
    input  logic [6:0] readRegisterRA_REG1,
    input  logic [6:0] readRegisterRB_REG1,
    input  logic [6:0] readRegisterRT_REG1,
    input  logic [6:0] readRegisterRA_REG2,
    input  logic [6:0] readRegisterRB_REG2,
    input  logic [6:0] readRegisterRT_REG2,
    input  logic [2:0] srcMask_REG1,
    input  logic [2:0] srcMask_REG2,
    input  logic [2:0] latency_REG1,
    input  logic [2:0] latency_REG2,
    input  logic       flush,
    output logic       issue_EX1,
    output logic       issue_EX2,
    output logic       bubble_EX1,
    output logic       bubble_EX2,
    output logic       stall_REG,
    output logic       sbFull
);

    localparam int CW = $clog2(MAX_LAT + 1);
    localparam int FW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_NORMAL,
        ST_SPLIT
    } state_t;

    state_t state_q, state_d;

    logic [DEPTH-1:0] sb_v_q, sb_v_d;
    logic [6:0]       sb_tag_q [DEPTH];
    logic [6:0]       sb_tag_d [DEPTH];
    logic [CW-1:0]    sb_cnt_q [DEPTH];
    logic [CW-1:0]    sb_cnt_d [DEPTH];

    logic          hz1_raw, hz2_raw, hz1, hz2, intra_dep, table_full;
    logic          we1_eff, we2_eff, alloc1, alloc2;
    logic [FW-1:0] free_cnt, writes_needed;
    logic [CW-1:0] lat1_eff, lat2_eff;

    assign we1_eff = valid_REG1 & regWriteEnable_REG1;
    assign we2_eff = valid_REG2 & regWriteEnable_REG2;

    // WAW is folded into the same tag compare as RAW by matching RT when the pipe writes.
    always_comb begin
        hz1_raw  = 1'b0;
        hz2_raw  = 1'b0;
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v_q[i]) begin
                if ((srcMask_REG1[0] && readRegisterRA_REG1 == sb_tag_q[i]) ||
                    (srcMask_REG1[1] && readRegisterRB_REG1 == sb_tag_q[i]) ||
                    (srcMask_REG1[2] && readRegisterRT_REG1 == sb_tag_q[i]) ||
                    (regWriteEnable_REG1 && readRegisterRT_REG1 == sb_tag_q[i]))
                    hz1_raw = 1'b1;
                if ((srcMask_REG2[0] && readRegisterRA_REG2 == sb_tag_q[i]) ||
                    (srcMask_REG2[1] && readRegisterRB_REG2 == sb_tag_q[i]) ||
                    (srcMask_REG2[2] && readRegisterRT_REG2 == sb_tag_q[i]) ||
                    (regWriteEnable_REG2 && readRegisterRT_REG2 == sb_tag_q[i]))
                    hz2_raw = 1'b1;
            end else begin
                free_cnt = free_cnt + FW'(1);
            end
        end
    end

    assign hz1        = valid_REG1 & hz1_raw;
    assign hz2        = valid_REG2 & hz2_raw;
    assign table_full = (free_cnt == '0);

    assign intra_dep = valid_REG2 && we1_eff &&
                       ((srcMask_REG2[0] && readRegisterRA_REG2 == readRegisterRT_REG1) ||
                        (srcMask_REG2[1] && readRegisterRB_REG2 == readRegisterRT_REG1) ||
                        (srcMask_REG2[2] && readRegisterRT_REG2 == readRegisterRT_REG1) ||
                        (regWriteEnable_REG2 && readRegisterRT_REG2 == readRegisterRT_REG1));

    assign writes_needed = FW'(we1_eff) + FW'(we2_eff);

    always_comb begin
        state_d    = state_q;
        issue_EX1  = 1'b0;
        bubble_EX1 = 1'b1;
        issue_EX2  = 1'b0;
        bubble_EX2 = 1'b1;
        stall_REG  = 1'b0;
        if (reset) begin
            state_d = ST_NORMAL;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (flush) begin
                        state_d = ST_NORMAL;
                    end else if (hz1 || (we1_eff && table_full)) begin
                        stall_REG = 1'b1;
                    end else if (intra_dep || hz2 || (writes_needed > free_cnt)) begin
                        issue_EX1  = valid_REG1;
                        bubble_EX1 = ~valid_REG1;
                        stall_REG  = 1'b1;
                        state_d    = ST_SPLIT;
                    end else begin
                        issue_EX1  = valid_REG1;
                        bubble_EX1 = ~valid_REG1;
                        issue_EX2  = valid_REG2;
                        bubble_EX2 = ~valid_REG2;
                    end
                end
                ST_SPLIT: begin
                    if (flush) begin
                        state_d = ST_NORMAL;
                    end else if (hz2 || (we2_eff && table_full)) begin
                        stall_REG = 1'b1;
                    end else begin
                        issue_EX2  = valid_REG2;
                        bubble_EX2 = ~valid_REG2;
                        state_d    = ST_NORMAL;
                    end
                end
                default: state_d = ST_NORMAL;
            endcase
        end
    end

    assign sbFull = ~reset & table_full;

    assign alloc1   = issue_EX1 & regWriteEnable_REG1;
    assign alloc2   = issue_EX2 & regWriteEnable_REG2;
    assign lat1_eff = (latency_REG1 == 3'd0) ? CW'(1) : CW'(latency_REG1);
    assign lat2_eff = (latency_REG2 == 3'd0) ? CW'(1) : CW'(latency_REG2);

    // Slots that free this edge are still valid in sb_v_q, so they are not reallocated until next cycle.
    always_comb begin
        logic done1, done2;
        sb_v_d   = sb_v_q;
        sb_tag_d = sb_tag_q;
        sb_cnt_d = sb_cnt_q;
        done1    = ~alloc1;
        done2    = ~alloc2;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v_q[i]) begin
                if (sb_cnt_q[i] > CW'(1))
                    sb_cnt_d[i] = sb_cnt_q[i] - CW'(1);
                else
                    sb_v_d[i] = 1'b0;
            end else if (!done1) begin
                sb_v_d[i]   = 1'b1;
                sb_tag_d[i] = readRegisterRT_REG1;
                sb_cnt_d[i] = lat1_eff;
                done1       = 1'b1;
            end else if (!done2) begin
                sb_v_d[i]   = 1'b1;
                sb_tag_d[i] = readRegisterRT_REG2;
                sb_cnt_d[i] = lat2_eff;
                done2       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NORMAL;
            sb_v_q  <= '0;
        end else begin
            state_q <= state_d;
            sb_v_q  <= sb_v_d;
        end
    end

    always_ff @(posedge clk) begin
        sb_tag_q <= sb_tag_d;
        sb_cnt_q <= sb_cnt_d;
    end

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// Directed bench for dual_issue_hazard_ctrl: inputs change 1ns after posedge, outputs sampled
// on negedge as {issue1, bubble1, issue2, bubble2, stall_REG, sbFull}.
module tb_dual_issue_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       valid_REG1, valid_REG2;
    logic       regWriteEnable_REG1, regWriteEnable_REG2;
    logic [6:0] readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRT_REG1;
    logic [6:0] readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRT_REG2;
    logic [2:0] srcMask_REG1, srcMask_REG2;
    logic [2:0] latency_REG1, latency_REG2;
    logic       flush;
    logic       issue_EX1, issue_EX2, bubble_EX1, bubble_EX2, stall_REG, sbFull;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] ISS_BOTH     = 6'b10_10_0_0;
    localparam logic [5:0] ISS1         = 6'b10_01_0_0;
    localparam logic [5:0] ISS2         = 6'b01_10_0_0;
    localparam logic [5:0] QUIET        = 6'b01_01_0_0;
    localparam logic [5:0] BUB_STALL    = 6'b01_01_1_0;
    localparam logic [5:0] BUB_STALL_F  = 6'b01_01_1_1;
    localparam logic [5:0] SPLIT_IN     = 6'b10_01_1_0;

    dual_issue_hazard_ctrl #(.DEPTH(8), .MAX_LAT(7)) dut (
        .clk                 (clk),
        .reset               (reset),
        .valid_REG1          (valid_REG1),
        .valid_REG2          (valid_REG2),
        .regWriteEnable_REG1 (regWriteEnable_REG1),
        .regWriteEnable_REG2 (regWriteEnable_REG2),
        .readRegisterRA_REG1 (readRegisterRA_REG1),
        .readRegisterRB_REG1 (readRegisterRB_REG1),
        .readRegisterRT_REG1 (readRegisterRT_REG1),
        .readRegisterRA_REG2 (readRegisterRA_REG2),
        .readRegisterRB_REG2 (readRegisterRB_REG2),
        .readRegisterRT_REG2 (readRegisterRT_REG2),
        .srcMask_REG1        (srcMask_REG1),
        .srcMask_REG2        (srcMask_REG2),
        .latency_REG1        (latency_REG1),
        .latency_REG2        (latency_REG2),
        .flush               (flush),
        .issue_EX1           (issue_EX1),
        .issue_EX2           (issue_EX2),
        .bubble_EX1          (bubble_EX1),
        .bubble_EX2          (bubble_EX2),
        .stall_REG           (stall_REG),
        .sbFull              (sbFull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_p1(input logic v, input logic we, input logic [6:0] ra, input logic [6:0] rb,
                          input logic [6:0] rt, input logic [2:0] m, input logic [2:0] lat);
        valid_REG1          = v;
        regWriteEnable_REG1 = we;
        readRegisterRA_REG1 = ra;
        readRegisterRB_REG1 = rb;
        readRegisterRT_REG1 = rt;
        srcMask_REG1        = m;
        latency_REG1        = lat;
    endtask

    task automatic set_p2(input logic v, input logic we, input logic [6:0] ra, input logic [6:0] rb,
                          input logic [6:0] rt, input logic [2:0] m, input logic [2:0] lat);
        valid_REG2          = v;
        regWriteEnable_REG2 = we;
        readRegisterRA_REG2 = ra;
        readRegisterRB_REG2 = rb;
        readRegisterRT_REG2 = rt;
        srcMask_REG2        = m;
        latency_REG2        = lat;
    endtask

    task automatic clear_pipes();
        set_p1(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1);
        set_p2(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1);
    endtask

    task automatic step(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        @(negedge clk);
        obs = {issue_EX1, bubble_EX1, issue_EX2, bubble_EX2, stall_REG, sbFull};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        clear_pipes();
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        clear_pipes();
        step("reset_outputs", QUIET);
        reset = 1'b0;

        // independent bundle, then both allocated tags block readers for 2 cycles
        set_p1(1'b1, 1'b1, 7'd10, 7'd11, 7'd3, 3'b011, 3'd2);
        set_p2(1'b1, 1'b1, 7'd10, 7'd11, 7'd4, 3'b011, 3'd2);
        step("t1_indep_issue", ISS_BOTH);
        set_p1(1'b1, 1'b0, 7'd3, 7'd0, 7'd0, 3'b001, 3'd1);
        set_p2(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1);
        step("t1_tag3_blocks", BUB_STALL);
        set_p1(1'b1, 1'b0, 7'd0, 7'd4, 7'd0, 3'b010, 3'd1);
        step("t1_tag4_blocks", BUB_STALL);
        step("t1_tags_freed", ISS1);

        // RAW/WAW on a lat-2 producer
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd5, 3'b000, 3'd2);
        step("t2_prod_issue", ISS1);
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd5, 3'b000, 3'd1);
        step("t2_waw_block_c1", BUB_STALL);
        set_p1(1'b1, 1'b0, 7'd5, 7'd0, 7'd0, 3'b001, 3'd1);
        step("t2_raw_block_c2", BUB_STALL);
        step("t2_raw_issue_c3", ISS1);

        // intra-bundle dependency with lat1 producer
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd9, 3'b000, 3'd1);
        set_p2(1'b1, 1'b0, 7'd0, 7'd9, 7'd0, 3'b010, 3'd1);
        step("t3_split_enter", SPLIT_IN);
        step("t3_split_hold", BUB_STALL);
        step("t3_issue2", ISS2);
        set_p1(1'b1, 1'b0, 7'd1, 7'd2, 7'd0, 3'b011, 3'd1);
        set_p2(1'b1, 1'b0, 7'd1, 7'd2, 7'd0, 3'b011, 3'd1);
        step("t3_back_normal", ISS_BOTH);

        // fill all 8 entries, full table stalls a writer until the first slots free
        for (int k = 0; k < 4; k++) begin
            set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'(30 + 2 * k), 3'b000, 3'd7);
            set_p2(1'b1, 1'b1, 7'd0, 7'd0, 7'(31 + 2 * k), 3'b000, 3'd7);
            step("t4_fill", ISS_BOTH);
        end
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd40, 3'b000, 3'd1);
        set_p2(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1);
        for (int k = 0; k < 4; k++) step("t4_full_stall", BUB_STALL_F);
        step("t4_issue_after_free", ISS1);
        idle_cycles(8);

        // one free entry, two writers: split on resources, SPLIT holds while full
        for (int k = 0; k < 3; k++) begin
            set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'(50 + 2 * k), 3'b000, 3'd7);
            set_p2(1'b1, 1'b1, 7'd0, 7'd0, 7'(51 + 2 * k), 3'b000, 3'd7);
            step("t4b_fill", ISS_BOTH);
        end
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd56, 3'b000, 3'd7);
        set_p2(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1);
        step("t4b_fill_one", ISS1);
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd57, 3'b000, 3'd7);
        set_p2(1'b1, 1'b1, 7'd0, 7'd0, 7'd58, 3'b000, 3'd7);
        step("t4b_resource_split", SPLIT_IN);
        for (int k = 0; k < 3; k++) step("t4b_split_full_hold", BUB_STALL_F);
        step("t4b_issue2", ISS2);
        idle_cycles(8);

        // flush in SPLIT and in NORMAL; scoreboard keeps counting
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd20, 3'b000, 3'd4);
        set_p2(1'b1, 1'b0, 7'd20, 7'd0, 7'd0, 3'b001, 3'd1);
        step("t5_split_enter", SPLIT_IN);
        flush = 1'b1;
        step("t5_flush_in_split", QUIET);
        flush = 1'b0;
        set_p1(1'b1, 1'b0, 7'd20, 7'd0, 7'd0, 3'b001, 3'd1);
        set_p2(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1);
        step("t5_normal_blocked_c2", BUB_STALL);
        flush = 1'b1;
        step("t5_flush_beats_hz1", QUIET);
        flush = 1'b0;
        step("t5_blocked_c4", BUB_STALL);
        step("t5_issue_c5", ISS1);

        // reset while in SPLIT with a live entry
        set_p1(1'b1, 1'b1, 7'd0, 7'd0, 7'd21, 3'b000, 3'd7);
        set_p2(1'b1, 1'b0, 7'd21, 7'd0, 7'd0, 3'b001, 3'd1);
        step("t6_split_enter", SPLIT_IN);
        step("t6_split_hold", BUB_STALL);
        reset = 1'b1;
        step("t6_reset_outputs", QUIET);
        reset = 1'b0;
        set_p1(1'b1, 1'b0, 7'd21, 7'd0, 7'd0, 3'b001, 3'd1);
        set_p2(1'b1, 1'b0, 7'd0, 7'd21, 7'd0, 3'b010, 3'd1);
        step("t6_post_reset_issue", ISS_BOTH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
